// File: rtl/clk_enable_sequencer.sv
// PLL-lock gated reset release plus phase-aligned clock-enable strobes.
// Define CLK_EN_SEQ_DIV_LOAD_EN to enable runtime divisor loading.
module clk_enable_sequencer #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 16,
  parameter int LOCK_WAIT = 1024,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = 32'h0800_0020
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic                    div_load,
  input  logic                    lock_lost_clr,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    rst_out,
  output logic                    locked_sync,
  output logic                    lock_lost
);

  localparam int SW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t        state;
  logic [SW-1:0] settle;
  logic          sync1;
  logic          in_run;
  logic          enter_run;

  assign in_run = (state == RUN);
  assign enter_run = (state == SETTLE) && locked_sync
                  && (settle == SW'(LOCK_WAIT - 1));

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1       <= 1'b0;
      locked_sync <= 1'b0;
    end else begin
      sync1       <= pll_locked;
      locked_sync <= sync1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= IDLE;
      settle    <= '0;
      rst_out   <= 1'b1;
      lock_lost <= 1'b0;
    end else begin
      unique case (state)
        IDLE: state <= WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_sync) begin
            state  <= SETTLE;
            settle <= '0;
          end
        end
        SETTLE: begin
          if (!locked_sync) begin
            state <= WAIT_LOCK;
          end else if (enter_run) begin
            state   <= RUN;
            rst_out <= 1'b0;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        RUN: begin
          if (!locked_sync) begin
            state   <= WAIT_LOCK;
            rst_out <= 1'b1;
          end
        end
      endcase
      // a new loss outranks a coincident clear
      lock_lost <= (in_run && !locked_sync)
                || (lock_lost && !lock_lost_clr);
    end
  end

`ifndef CLK_EN_SEQ_DIV_LOAD_EN
  logic unused_div;
  assign unused_div = ^{div_in, div_load};
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] nxt_div;
    logic             wrap;

    assign wrap = (cnt == '0);
    assign ce_out[k] = in_run && wrap && (act != '0);

`ifdef CLK_EN_SEQ_DIV_LOAD_EN
    logic [DIV_W-1:0] shd;
    logic [DIV_W-1:0] new_div;
    logic             pend;

    assign new_div = div_load ? div_in[k*DIV_W +: DIV_W] : shd;
    assign nxt_div = (div_load || pend) ? new_div : act;

    always_ff @(posedge refclk) begin
      if (rst) begin
        shd  <= DIV_INIT[k*DIV_W +: DIV_W];
        act  <= DIV_INIT[k*DIV_W +: DIV_W];
        pend <= 1'b0;
      end else begin
        if (div_load) shd <= div_in[k*DIV_W +: DIV_W];
        // divisor only changes on a wrap while running
        if (!in_run || wrap) begin
          act  <= nxt_div;
          pend <= 1'b0;
        end else begin
          pend <= pend || div_load;
        end
      end
    end
`else
    assign act = DIV_INIT[k*DIV_W +: DIV_W];
    assign nxt_div = act;
`endif

    always_ff @(posedge refclk) begin
      if (rst) begin
        cnt <= '0;
      end else if (enter_run || (in_run && wrap)) begin
        cnt <= (nxt_div == '0) ? '0 : nxt_div - DIV_W'(1);
      end else if (in_run) begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_sequencer.sv
// Directed bench for clk_enable_sequencer (default parameters).
// Divisor-load scenarios follow the CLK_EN_SEQ_DIV_LOAD_EN build.
module tb_clk_enable_sequencer;

  logic        refclk = 1'b0;
  logic        rst;
  logic        pll_locked;
  logic [31:0] div_in;
  logic        div_load;
  logic        lock_lost_clr;
  logic [1:0]  ce_out;
  logic        rst_out;
  logic        locked_sync;
  logic        lock_lost;

  int checks = 0;
  int failures = 0;
  int rc = 0;

  always #5 refclk = ~refclk;

  clk_enable_sequencer dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .div_in(div_in),
    .div_load(div_load),
    .lock_lost_clr(lock_lost_clr),
    .ce_out(ce_out),
    .rst_out(rst_out),
    .locked_sync(locked_sync),
    .lock_lost(lock_lost)
  );

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic run_to(int n);
    step(n - rc);
    rc = n;
  endtask

  initial begin
    int n0;
    int n1;
    rst = 1'b1;
    pll_locked = 1'b1;
    div_in = '0;
    div_load = 1'b0;
    lock_lost_clr = 1'b0;
    step(3);
    check("rst_rst_out", rst_out, 1);
    check("rst_ce", ce_out, 0);
    check("rst_locked_sync", locked_sync, 0);
    check("rst_lock_lost", lock_lost, 0);

    rst = 1'b0;
    step(1);
    check("sync_lat1", locked_sync, 0);
    step(1);
    check("sync_lat2", locked_sync, 1);
    step(1024);
    check("rel_pre", rst_out, 1);
    step(1);
    check("rel", rst_out, 0);
    rc = 1;
    check("run1_ce", ce_out, 0);
    run_to(31);   check("ce_31", ce_out, 2'b00);
    run_to(32);   check("ce_32", ce_out, 2'b01);
    run_to(33);   check("ce_33", ce_out, 2'b00);
    run_to(64);   check("ce_64", ce_out, 2'b01);
    run_to(2047); check("ce_2047", ce_out, 2'b00);
    run_to(2048); check("ce_2048", ce_out, 2'b11);
    run_to(2049); check("ce_2049", ce_out, 2'b00);
    run_to(4095); check("ce_4095", ce_out, 2'b00);
    run_to(4096); check("ce_4096", ce_out, 2'b11);

    pll_locked = 1'b0;
    step(2);
    check("loss_still_run", rst_out, 0);
    step(1);
    check("loss_rst_out", rst_out, 1);
    check("loss_ce", ce_out, 0);
    check("loss_flag", lock_lost, 1);

    pll_locked = 1'b1;
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    check("clr_flag", lock_lost, 0);
    step(502);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(523);
    check("glitch_no_early", rst_out, 1);
    step(503);
    check("glitch_pre", rst_out, 1);
    step(1);
    check("glitch_rel", rst_out, 0);
    check("glitch_flag", lock_lost, 0);
    rc = 1;

    run_to(40);
    pll_locked = 1'b0;
    step(2);
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    check("setclr_flag", lock_lost, 1);
    check("setclr_rst_out", rst_out, 1);
    pll_locked = 1'b1;
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    check("clr2_flag", lock_lost, 0);
    step(1025);
    check("rel2_pre", rst_out, 1);
    step(1);
    check("rel2", rst_out, 0);
    rc = 1;

`ifdef CLK_EN_SEQ_DIV_LOAD_EN
    run_to(32);
    check("wrap_ce_32", ce_out, 2'b01);
    div_in = {16'd2048, 16'd64};
    div_load = 1'b1;
    step(1);
    rc = 33;
    div_load = 1'b0;
    run_to(64);  check("wl_ce_64", ce_out, 2'b00);
    run_to(95);  check("wl_ce_95", ce_out, 2'b00);
    run_to(96);  check("wl_ce_96", ce_out, 2'b01);
    run_to(100);
    div_in = {16'd2048, 16'd32};
    div_load = 1'b1;
    step(1);
    rc = 101;
    div_load = 1'b0;
    run_to(128); check("mid32_ce_128", ce_out, 2'b00);
    run_to(160); check("mid32_ce_160", ce_out, 2'b01);
    run_to(170);
    div_in = {16'd2048, 16'd64};
    div_load = 1'b1;
    step(1);
    rc = 171;
    div_load = 1'b0;
    run_to(192); check("mid64_ce_192", ce_out, 2'b01);
    run_to(224); check("mid64_ce_224", ce_out, 2'b00);
    run_to(255); check("mid64_ce_255", ce_out, 2'b00);
    run_to(256); check("mid64_ce_256", ce_out, 2'b01);

    pll_locked = 1'b0;
    step(3);
    check("idle_ce", ce_out, 0);
    div_in = {16'd0, 16'd1};
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    pll_locked = 1'b1;
    step(1026);
    check("rel3_pre", rst_out, 1);
    step(1);
    check("rel3", rst_out, 0);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 2100; i++) begin
      n0 += int'(ce_out[0]);
      n1 += int'(ce_out[1]);
      step(1);
    end
    check("div1_count", n0, 2100);
    check("div0_count", n1, 0);
`else
    run_to(10);
    div_in = '0;
    div_load = 1'b1;
    step(1);
    rc = 11;
    div_load = 1'b0;
    run_to(32);
    check("fix_ce_32", ce_out, 2'b01);
    div_load = 1'b1;
    step(1);
    rc = 33;
    div_load = 1'b0;
    run_to(63);   check("fix_ce_63", ce_out, 2'b00);
    run_to(64);   check("fix_ce_64", ce_out, 2'b01);
    run_to(2048); check("fix_ce_2048", ce_out, 2'b11);
    run_to(2079);
`endif

    rst = 1'b1;
    step(1);
    check("midrst_rst_out", rst_out, 1);
    check("midrst_ce", ce_out, 0);
    check("midrst_sync", locked_sync, 0);
    rst = 1'b0;
    step(1026);
    check("rel4_pre", rst_out, 1);
    step(1);
    check("rel4", rst_out, 0);
    rc = 1;
    run_to(31); check("init_ce_31", ce_out, 2'b00);
    run_to(32); check("init_ce_32", ce_out, 2'b01);
    run_to(64); check("init_ce_64", ce_out, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
